// File: rtl/rx_sym_pkg.sv
//==============================================================================
// Module : rx_sym_pkg
// Brief  : Shared field positions, COM byte, lock-FSM encoding and idle symbol
//          for the Rx symbol-pair aligner.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rx_sym_pkg;

    localparam int SYM_W     = 14;
    localparam int DATA_MSB  = 13;
    localparam int DATA_LSB  = 6;
    localparam int K_BIT     = 5;
    localparam int DISP_BIT  = 4;
    localparam int CV_BIT    = 3;
    localparam int VALID_BIT = 2;
    localparam int IDLE_BIT  = 1;
    localparam int PHYST_BIT = 0;

    localparam logic [7:0]       COM_BYTE = 8'hBC;
    localparam logic [SYM_W-1:0] IDLE_SYM = 14'h0002;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_com_detect.sv
//==============================================================================
// Module : rx_com_detect
// Brief  : Per-symbol K28.5 (COM) and code-violation detection, combinational.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rx_com_detect
    import rx_sym_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_cv,
    output logic       o_is_com,
    output logic       o_is_cv
);

    // A violated symbol cannot be trusted as a comma even if the byte matches.
    assign o_is_com = i_k && (i_data == COM_BYTE) && !i_cv;
    assign o_is_cv  = i_cv;

endmodule

`default_nettype wire

// File: rtl/rx_sym_align.sv
//==============================================================================
// Module : rx_sym_align
// Brief  : Aligns the 2-symbol Rx word so COM lands in the upper slot, tracks
//          comma lock and counts code violations.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rx_sym_align
    import rx_sym_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int BAD_MAX  = 2,
    parameter int GWIDTH   = 14
) (
    input  logic                clk_125,
    input  logic                rst,
    input  logic [2*GWIDTH-1:0] data_in,
    input  logic                cv_clr,
    output logic [2*GWIDTH-1:0] data_out,
    output logic                sym_locked,
    output logic                shift,
    output logic [7:0]          cv_count
);

    localparam logic [3:0] C_LOCK_CNT = 4'(LOCK_CNT);
    localparam logic [2:0] C_BAD_MAX  = 3'(BAD_MAX);

    logic [GWIDTH-1:0]   w_up;
    logic [GWIDTH-1:0]   w_lo;
    logic                w_up_com;
    logic                w_lo_com;
    logic                w_up_cv;
    logic                w_lo_cv;
    logic                w_idle;
    logic                w_com_any;
    logic                w_correct;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_shift;
    logic                w_shift_nxt;
    logic [3:0]          r_good;
    logic [3:0]          w_good_nxt;
    logic [2:0]          r_bad;
    logic [2:0]          w_bad_nxt;
    logic                r_locked;
    logic [GWIDTH-1:0]   r_prev_lower;
    logic [2*GWIDTH-1:0] r_data_out;
    logic [2*GWIDTH-1:0] w_aligned;
    logic [7:0]          r_cv;
    logic [8:0]          w_cv_sum;

    assign w_up = data_in[2*GWIDTH-1:GWIDTH];
    assign w_lo = data_in[GWIDTH-1:0];

    rx_com_detect u_det_up (
        .i_data   (w_up[DATA_MSB:DATA_LSB]),
        .i_k      (w_up[K_BIT]),
        .i_cv     (w_up[CV_BIT]),
        .o_is_com (w_up_com),
        .o_is_cv  (w_up_cv)
    );

    rx_com_detect u_det_lo (
        .i_data   (w_lo[DATA_MSB:DATA_LSB]),
        .i_k      (w_lo[K_BIT]),
        .i_cv     (w_lo[CV_BIT]),
        .o_is_com (w_lo_com),
        .o_is_cv  (w_lo_cv)
    );

    assign w_idle    = w_up[IDLE_BIT] | w_lo[IDLE_BIT];
    assign w_com_any = w_up_com | w_lo_com;
    // Upper slot wins when both carry a COM, so only a lone lower COM counts as lower.
    assign w_correct = w_up_com ? !r_shift : (w_lo_com & r_shift);

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            r_state  <= UNLOCKED;
            r_shift  <= 1'b0;
            r_good   <= 4'd0;
            r_bad    <= 3'd0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_good   <= w_good_nxt;
            r_bad    <= w_bad_nxt;
            r_locked <= (w_state_nxt == LOCKED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        if (w_idle) begin
            w_state_nxt = UNLOCKED;
            w_shift_nxt = 1'b0;
            w_good_nxt  = 4'd0;
            w_bad_nxt   = 3'd0;
        end else if (w_com_any) begin
            case (r_state)
                UNLOCKED: begin
                    w_shift_nxt = !w_up_com;
                    w_good_nxt  = 4'd1;
                    w_state_nxt = CHECK;
                end
                CHECK: begin
                    if (w_correct) begin
                        if (r_good >= C_LOCK_CNT - 4'd1) begin
                            w_good_nxt  = C_LOCK_CNT;
                            w_bad_nxt   = 3'd0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_good_nxt = r_good + 4'd1;
                        end
                    end else begin
                        w_shift_nxt = !r_shift;
                        w_good_nxt  = 4'd1;
                    end
                end
                LOCKED: begin
                    if (w_correct) begin
                        w_bad_nxt = 3'd0;
                    end else if (r_bad >= C_BAD_MAX - 3'd1) begin
                        w_bad_nxt   = C_BAD_MAX;
                        w_state_nxt = UNLOCKED;
                    end else begin
                        w_bad_nxt = r_bad + 3'd1;
                    end
                end
                default: w_state_nxt = UNLOCKED;
            endcase
        end
    end

    // The word built with a freshly changed shift may drop or repeat a symbol.
    always_comb begin
        w_aligned = w_shift_nxt ? {r_prev_lower, w_up} : data_in;
        if (w_shift_nxt != r_shift) begin
            w_aligned[GWIDTH+VALID_BIT] = 1'b0;
            w_aligned[VALID_BIT]        = 1'b0;
        end
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            r_prev_lower <= IDLE_SYM;
            r_data_out   <= {IDLE_SYM, IDLE_SYM};
        end else begin
            r_prev_lower <= w_lo;
            r_data_out   <= w_aligned;
        end
    end

    assign w_cv_sum = {1'b0, r_cv} + {8'd0, w_up_cv} + {8'd0, w_lo_cv};

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            r_cv <= 8'd0;
        end else if (cv_clr) begin
            r_cv <= 8'd0;
        end else if (w_cv_sum[8]) begin
            r_cv <= 8'hFF;
        end else begin
            r_cv <= w_cv_sum[7:0];
        end
    end

    assign data_out   = r_data_out;
    assign sym_locked = r_locked;
    assign shift      = r_shift;
    assign cv_count   = r_cv;

endmodule

`default_nettype wire

// File: doc/rx_sym_align.md
# rx_sym_align

Symbol-pair aligner and comma-lock monitor directly downstream of the Rx rate-conversion gear. Consumes the 2-symbol, 28-bit word produced at 125 MHz, detects K28.5 (COM) and realigns so every COM lands in the upper (earlier) symbol slot. Tracks alignment lock with a small state machine and counts code violations. Feeds the ordered-set / SKP handling logic.

## Interface
- LOCK_CNT, 4: consecutive same-slot COMs required to declare lock (2..15)
- BAD_MAX, 2: consecutive wrong-slot COMs while locked before lock is dropped (1..7)
- GWIDTH, 14: bits per symbol; the field layout below is fixed for 14
- clk_125  in  1  125 MHz clock; single clock domain
- rst  in  1  reset; **asynchronous, active-high**
- data_in  in  2*GWIDTH  symbol pair from gear; [27:14] earlier symbol, [13:0] later symbol
- cv_clr  in  1  synchronous clear of cv_count
- data_out  out  2*GWIDTH  aligned symbol pair, same layout as data_in
- sym_locked  out  1  alignment lock achieved
- shift  out  1  1 = output built from {previous lower, current upper}
- cv_count  out  8  saturating code-violation count

Per-symbol field layout: [13:6] data byte, [5] K flag, [4] disparity error, [3] code violation, [2] rx_valid, [1] elec_idle, [0] phy_status.

## Operation
- COM detect per symbol: K=1, data=8'hBC, code violation=0. Upper slot has priority if both slots detect.
- Alignment mux: shift=0 -> out = cur word; shift=1 -> out = {prev_lower, cur_upper}. prev_lower is registered every cycle.
- States: UNLOCKED, CHECK, LOCKED. Registers: good_cnt (4 b), bad_cnt (3 b).
- COM slot is "correct" when it is the upper slot with shift=0, or the lower slot with shift=1. Under shift=1, a lower-slot COM becomes the upper symbol of the next output word.
- UNLOCKED: a COM in either slot sets shift to place it upper, good_cnt=1, go to CHECK.
- CHECK: correct-slot COM increments good_cnt; when it reaches LOCK_CNT, go to LOCKED and clear bad_cnt. Wrong-slot COM toggles shift, sets good_cnt=1, and stays in CHECK.
- LOCKED: correct-slot COM clears bad_cnt. Wrong-slot COM increments bad_cnt; at BAD_MAX go to UNLOCKED and leave shift unchanged.
- elec_idle=1 in either input symbol forces UNLOCKED, clears shift, good_cnt and bad_cnt. This overrides any COM in the same cycle.
- Shift change: in the first output word after shift changes, rx_valid is forced to 0 in both symbols because a symbol may be dropped or duplicated.
- cv_count increments by 1 for each input symbol with bit[3]=1. Two violations in one word add 2. The count saturates at 255. cv_clr has priority over the increment in the same cycle.
- sym_locked = (state == LOCKED).

## Timing
- All outputs are registered. data_out has a latency of 1 clk_125 with shift=0; the upper symbol is delayed 1.5 words with shift=1.
- A state change is visible on sym_locked 1 cycle after the triggering input word. shift updates in the same cycle as the state.
- Reset values:
  - data_out = {14'h0002, 14'h0002} (elec_idle high, matching the gear's idle output)
  - sym_locked = 0, shift = 0, cv_count = 0
  - state UNLOCKED, counters 0
- Reset assertion mid-operation returns to these values immediately, without waiting for a clock.
- Counter boundaries:
  - good_cnt saturates at LOCK_CNT.
  - bad_cnt saturates at BAD_MAX.
  - cv_count holds at 255 until cv_clr.

## Structure
- Package rx_sym_pkg holds:
  - field bit-position constants
  - COM_BYTE = 8'hBC
  - the state encoding (UNLOCKED=2'd0, CHECK=2'd1, LOCKED=2'd2)
  - the idle symbol constant 14'h0002
- One sub-module, rx_com_detect: combinational, per symbol; outputs is_com and is_cv; instantiated twice.
- The state machine, alignment mux and counters live in the top-level block.

## Test plan
- Reset: assert rst -> data_out = 28'h0008002, sym_locked=0, cv_count=0.
- Upper-slot COM every 8 words, 4 times -> shift stays 0; sym_locked rises 1 cycle after the 4th COM word.
- Lower-slot COM every 8 words -> shift=1 after the first; that output word has rx_valid=0; COM (data 8'hBC, K=1) appears in bits [27:14] on later words; lock after the 4th.
- While locked, 2 consecutive wrong-slot COMs -> sym_locked drops after the 2nd. A single wrong-slot COM followed by a correct one -> lock held and bad_cnt cleared.
- elec_idle=1 in a word that also carries a correct COM while locked -> sym_locked=0 and shift=0 next cycle.
- 300 words with code violations in both symbols, then cv_clr on the same cycle as a violation -> cv_count saturates at 255, then reads 0.
